imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 98 +++++++++
 tb/tb_imm_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// LEGv8 immediate encoder: inserts a signed immediate into the D-type (LDUR/STUR)
// or CB-type (CBZ) field of a base word. Define IMM_ENCODER_SAT_EN to clamp out-of-range values.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] base,
    input  logic [63:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    logic        out_valid_q, out_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        is_d, is_cb, d_in_range, cb_in_range;
    logic [8:0]  imm9;
    logic [18:0] imm19;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        xfer, accept;

    // In range exactly when every bit above the field's sign bit copies that sign bit.
    always_comb begin
        is_d        = (base[31:21] == OPC_LDUR) || (base[31:21] == OPC_STUR);
        is_cb       = (base[31:24] == OPC_CBZ);
        d_in_range  = (&imm[63:8])  || !(|imm[63:8]);
        cb_in_range = (&imm[63:18]) || !(|imm[63:18]);
`ifdef IMM_ENCODER_SAT_EN
        imm9  = d_in_range  ? imm[8:0]  : (imm[63] ? 9'h100   : 9'h0FF);
        imm19 = cb_in_range ? imm[18:0] : (imm[63] ? 19'h40000 : 19'h3FFFF);
`else
        imm9  = imm[8:0];
        imm19 = imm[18:0];
`endif
        enc_instr = base;
        enc_err   = 1'b1;
        if (is_d) begin
            enc_instr[20:12] = imm9;
            enc_err          = !d_in_range;
        end else if (is_cb) begin
            enc_instr[23:5] = imm19;
            enc_err         = !cb_in_range;
        end
    end

    // Valid/ready: a word moves on any cycle where valid and ready are both high;
    // the output register may be refilled on the same cycle its word is accepted.
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        xfer        = in_valid && in_ready;
        accept      = out_valid_q && out_ready;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        if (accept && err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
        if (xfer) begin
            out_valid_d = 1'b1;
            instr_d     = enc_instr;
            err_d       = enc_err;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table through a scoreboard queue, plus stall,
// saturation and mid-stall reset sequences.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_count;

    imm_encoder dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .err_count (err_count)
    );

    typedef struct {
        logic [31:0] base;
        logic [63:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    logic [32:0] exp_q[$];
    int          checks;
    int          errors;
    int          pops;
    logic [7:0]  exp_err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, actual=running required=done");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, then observe handshakes.
    task automatic cycle(input logic v, input logic [31:0] b, input logic [63:0] i,
                         input logic orr, input logic [31:0] ei, input logic ee);
        logic [32:0] e;
        @(negedge clk);
        in_valid  = v;
        base      = b;
        imm       = i;
        out_ready = orr;
        #1;
        if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("unexpected word", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("instr", instr, e[32:1]);
                check("err", {31'd0, err}, {31'd0, e[0]});
                if (e[0] && exp_err_cnt != 8'hFF) exp_err_cnt++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back({ei, ee});
    endtask

    task automatic drive_vec(input int k, input logic v, input logic orr);
        cycle(v, vecs[k].base, vecs[k].imm, orr, vecs[k].exp_instr, vecs[k].exp_err);
    endtask

    task automatic drain();
        for (int n = 0; n < 10; n++) begin
            if (exp_q.size() == 0) break;
            cycle(1'b0, 32'd0, 64'd0, 1'b1, 32'd0, 1'b0);
        end
        check("drain empty", exp_q.size(), 32'd0);
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 32'd0, 1'b0);
        check("idle out_valid", {31'd0, out_valid}, 32'd0);
        check("err_count", {24'd0, err_count}, {24'd0, exp_err_cnt});
    endtask

    initial begin
        int p0;
        checks = 0; errors = 0; pops = 0; exp_err_cnt = 8'd0;
        vecs[0]  = '{32'hF8400022, 64'h55,                 32'hF8455022, 1'b0};
        vecs[1]  = '{32'hF8400022, 64'hFFFFFFFFFFFFFFAA,   32'hF85AA022, 1'b0};
        vecs[2]  = '{32'hB4000001, 64'hF,                  32'hB40001E1, 1'b0};
        vecs[3]  = '{32'hB4000001, 64'hFFFFFFFFFFFFFFFF,   32'hB4FFFFE1, 1'b0};
`ifdef IMM_ENCODER_SAT_EN
        vecs[4]  = '{32'hF8400022, 64'd256,                32'hF84FF022, 1'b1};
        vecs[7]  = '{32'hF8400022, -64'sd257,              32'hF8500022, 1'b1};
        vecs[11] = '{32'hB4000001, 64'd262144,             32'hB47FFFE1, 1'b1};
`else
        vecs[4]  = '{32'hF8400022, 64'd256,                32'hF8500022, 1'b1};
        vecs[7]  = '{32'hF8400022, -64'sd257,              32'hF84FF022, 1'b1};
        vecs[11] = '{32'hB4000001, 64'd262144,             32'hB4800001, 1'b1};
`endif
        vecs[5]  = '{32'hF8400022, 64'd255,                32'hF84FF022, 1'b0};
        vecs[6]  = '{32'hF8400022, -64'sd256,              32'hF8500022, 1'b0};
        vecs[8]  = '{32'hF8000000, 64'd1,                  32'hF8001000, 1'b0};
        vecs[9]  = '{32'hB4000001, 64'd262143,             32'hB47FFFE1, 1'b0};
        vecs[10] = '{32'hB4000001, -64'sd262144,           32'hB4800001, 1'b0};
        vecs[12] = '{32'h8B020020, 64'd5,                  32'h8B020020, 1'b1};
        vecs[13] = '{32'hF85FF3E1, 64'd0,                  32'hF84003E1, 1'b0};
        vecs[14] = '{32'hB4FFFFFF, 64'd0,                  32'hB400001F, 1'b0};
        vecs[15] = '{32'hF8600022, 64'd7,                  32'hF8600022, 1'b1};

        // Reset state.
        rst_n = 1'b0; in_valid = 1'b0; base = '0; imm = '0; out_ready = 1'b0;
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset instr", instr, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset err_count", {24'd0, err_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 64'd0, 1'b0, 32'd0, 1'b0);
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // Latency: the word is visible one edge after its transfer.
        drive_vec(0, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b0, 32'd0, 1'b0);
        check("latency out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Full table back-to-back with the consumer always ready.
        p0 = pops;
        for (int k = 0; k < NV; k++) begin
            drive_vec(k, 1'b1, 1'b1);
            check("b2b in_ready", {31'd0, in_ready}, 32'd1);
        end
        drain();
        check("b2b words delivered", pops - p0, NV);

        // Stall: consumer holds off for five cycles while a new request waits.
        p0 = pops;
        drive_vec(2, 1'b1, 1'b1);
        for (int s = 0; s < 5; s++) begin
            drive_vec(5, 1'b1, 1'b0);
            check("stall in_ready", {31'd0, in_ready}, 32'd0);
            check("stall out_valid", {31'd0, out_valid}, 32'd1);
            check("stall instr", instr, vecs[2].exp_instr);
        end
        drive_vec(5, 1'b1, 1'b1);
        drain();
        check("stall words delivered", pops - p0, 2);

        // Random traffic over the table.
        for (int r = 0; r < 200; r++) begin
            drive_vec($urandom_range(0, NV - 1), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Saturation of the error counter.
        for (int r = 0; r < 300; r++) begin
            drive_vec(12, 1'b1, 1'b1);
        end
        drain();
        check("err_count saturated", {24'd0, err_count}, 32'd255);

        // Reset while a word is held by a stalled consumer.
        drive_vec(12, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b0, 32'd0, 1'b0);
        check("held before reset", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid reset err_count", {24'd0, err_count}, 32'd0);
        check("mid reset instr", instr, 32'd0);
        exp_q.delete();
        exp_err_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 32'd0, 1'b0);
        check("post reset in_ready", {31'd0, in_ready}, 32'd1);
        check("post reset err_count", {24'd0, err_count}, 32'd0);
        drive_vec(3, 1'b1, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
